mem_arbiter: RTL
================

// Module: mem_arbiter
//
// PURPOSE
//   Shares the single 16-bit-address memory port between two bus masters:
//   m0 = cpu core, m1 = loader/DMA.
//   Round-robin arbitration, one outstanding read at a time.
//   Routes read data back to the master that issued the read.
//   A watchdog counter converts a missing rd_valid into an error
//   completion so a master never hangs.
//
// PARAMETERS
//   W        32            data width (wdata/rdata)
//   AW       16            address width
//   TIMEOUT  16            max cycles in RD_WAIT before forced completion (>=2)
//   ERR_DATA 32'hDEADBEEF  rdata returned on a timed-out read
//
// PORTS
//   clk                 in   1   clock, all state on posedge
//   rst_n               in   1   asynchronous active-low reset
//   m0_ren / m1_ren     in   1   read request, held until granted
//   m0_wen / m1_wen     in   1   write request, held until granted
//   m0_addr / m1_addr   in   AW  request address
//   m0_wdata / m1_wdata in   W   write data
//   m0_wmask / m1_wmask in   4   byte write mask
//   m0_gnt / m1_gnt     out  1   request accepted this cycle
//   m0_rdata / m1_rdata out  W   read data (valid only with rd_valid)
//   m0_rd_valid / m1_rd_valid  out  1   read completion pulse
//   mem_ren, mem_wen    out  1   memory read / write strobe
//   mem_addr            out  AW  memory address
//   mem_wdata           out  W   memory write data
//   mem_wmask           out  4   memory byte mask
//   mem_rdata           in   W   memory read data
//   mem_rd_valid        in   1   memory read completion
//   timeout             out  1   one-cycle pulse on forced read completion
//
// BEHAVIOUR
//   - Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
//   - Reset state: state=IDLE, last=1 (m0 wins first tie), cnt=0.
//     All outputs 0 while rst_n=0.
//   - Reset mid-read aborts the read; no rd_valid is issued afterwards.
//   - States: IDLE, RD_WAIT.
//   - Request: mN_req = mN_ren | mN_wen. If both are set, wen wins and
//     the request is treated as a write.
//   - IDLE grant (combinational):
//     - only one master requests: it wins;
//     - both request: winner = !last.
//     - gnt is high only in IDLE; on a grant, last <= winner.
//   - Memory outputs:
//     - mem_* mirror the winner's addr/wdata/wmask/ren/wen combinationally
//       in the grant cycle; otherwise all mem_* are 0.
//     - mem_wmask is 0 when there is no grant.
//   - Write: single cycle. State stays IDLE, so a new grant is possible
//     the next cycle.
//   - Read grant: owner <= winner, cnt <= 0, state -> RD_WAIT.
//   - RD_WAIT:
//     - no grants are issued; cnt increments each cycle.
//     - mem_rd_valid=1: owner_rdata = mem_rdata and owner_rd_valid=1,
//       same cycle (combinational); next state IDLE.
//     - cnt == TIMEOUT-1 and !mem_rd_valid: owner_rd_valid=1,
//       rdata=ERR_DATA, timeout=1; next state IDLE.
//     - mem_rd_valid and the terminal count in the same cycle: data wins,
//       no timeout pulse.
//   - Non-owner rd_valid is always 0 and its rdata is 0.
//   - mem_rd_valid seen in IDLE (stray or late after timeout) is dropped.
//     Neither master sees it.
//   - Minimum read turnaround: grant cycle, then >=1 RD_WAIT cycle, then
//     IDLE. The next grant comes at the earliest one cycle after the
//     completion.
//   - Masters must hold ren/wen/addr/wdata/wmask stable until gnt.
//   - The arbiter never asserts mem_ren and mem_wen together.
//
// TESTING
//   1. m0 read 0x0010 alone, memory answers 0x11223344 two cycles later:
//      - m0_gnt in cycle 0; m0_rd_valid with 0x11223344 in cycle 2;
//      - m1_rd_valid stays 0.
//   2. m0 and m1 write every cycle, back to back:
//      - grants alternate m0, m1, m0, ... with m0 first after reset;
//      - mem_wmask tracks the granted master.
//   3. m1 read, m0 write pending:
//      - m0 is held off (m0_gnt=0) through all of RD_WAIT;
//      - m0 is granted the cycle after m1_rd_valid.
//   4. m0 read, memory never answers (TIMEOUT=16):
//      - m0_rd_valid=1, rdata=0xDEADBEEF, timeout=1 on the 16th RD_WAIT
//        cycle;
//      - a later stray mem_rd_valid is ignored.
//   5. mem_rd_valid exactly at the terminal count:
//      - real data is returned; timeout stays 0.
//   6. rst_n pulled low during RD_WAIT:
//      - outputs go to 0 immediately; no rd_valid after release;
//      - the first tie after release is won by m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between two masters: m0 (cpu core) and
//   m1 (loader/DMA). Arbitration is round-robin. At most one read is
//   outstanding at a time. Read data is routed back to the master that
//   issued the read. A watchdog turns a missing mem_rd_valid into an error
//   completion (ERR_DATA plus a timeout pulse), so a master never hangs.
//
// Handshake: a master raises ren or wen and holds ren/wen/addr/wdata/wmask
//   stable until it sees its gnt high. A request counts as accepted in the
//   cycle where gnt is high, and it should be dropped or replaced on the
//   next cycle. Read completion is a one-cycle rd_valid pulse, and rdata is
//   valid only in that cycle. The memory side has no back-pressure. The
//   strobes mem_ren/mem_wen are high for exactly the grant cycle, and
//   mem_rd_valid is accepted in any RD_WAIT cycle.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   mN_ren / mN_wen       read / write request (wen wins if both are set)
//   mN_addr/wdata/wmask   request payload
//   mN_gnt                request accepted this cycle
//   mN_rdata/mN_rd_valid  read completion for master N
//   mem_*                 memory port (strobes, address, data, mask)
//   timeout               one-cycle pulse on a forced read completion
//   o_dbg_state           current FSM state (0 = IDLE, 1 = RD_WAIT)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int          W        = 32,
  parameter int          AW       = 16,
  parameter int          TIMEOUT  = 16,
  parameter logic [W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_ren,
  input  logic          m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [W-1:0]  m0_wdata,
  input  logic [3:0]    m0_wmask,
  input  logic          m1_ren,
  input  logic          m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [W-1:0]  m1_wdata,
  input  logic [3:0]    m1_wmask,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic [W-1:0]  m0_rdata,
  output logic [W-1:0]  m1_rdata,
  output logic          m0_rd_valid,
  output logic          m1_rd_valid,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_rd_valid,
  output logic          timeout,
  output logic          o_dbg_state
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RD_WAIT = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_last;   // master that won the most recent grant
  logic          r_owner;  // master that owns the outstanding read
  logic [CW-1:0] r_cnt;    // cycles spent in RD_WAIT so far

  logic          w_req0, w_req1, w_win, w_grant, w_sel_wen;
  logic          w_rd_wait, w_done_data, w_done_to, w_done;
  logic [W-1:0]  w_cpl_data;

  assign w_req0 = m0_ren | m0_wen;
  assign w_req1 = m1_ren | m1_wen;
  // m1 wins if it is the sole requester, or if both request and m0 won last.
  assign w_win  = w_req1 & (~w_req0 | ~r_last);
  // The rst_n term keeps every combinational output at 0 while reset is held.
  assign w_grant   = rst_n && (r_state == S_IDLE) && (w_req0 || w_req1);
  assign w_sel_wen = w_win ? m1_wen : m0_wen;

  assign m0_gnt    = w_grant & ~w_win;
  assign m1_gnt    = w_grant &  w_win;
  // A write has priority over a read, so the strobes are exclusive.
  assign mem_wen   = w_grant &  w_sel_wen;
  assign mem_ren   = w_grant & ~w_sel_wen;
  assign mem_addr  = !w_grant ? '0 : (w_win ? m1_addr  : m0_addr);
  assign mem_wdata = !w_grant ? '0 : (w_win ? m1_wdata : m0_wdata);
  assign mem_wmask = !w_grant ? '0 : (w_win ? m1_wmask : m0_wmask);

  // Real data beats the terminal count if both occur in the same cycle.
  assign w_rd_wait   = rst_n && (r_state == S_RD_WAIT);
  assign w_done_data = w_rd_wait & mem_rd_valid;
  assign w_done_to   = w_rd_wait & ~mem_rd_valid & (r_cnt == CNT_LAST);
  assign w_done      = w_done_data | w_done_to;
  assign w_cpl_data  = w_done_data ? mem_rdata : ERR_DATA;

  assign m0_rd_valid = w_done & ~r_owner;
  assign m1_rd_valid = w_done &  r_owner;
  assign m0_rdata    = m0_rd_valid ? w_cpl_data : '0;
  assign m1_rdata    = m1_rd_valid ? w_cpl_data : '0;
  assign timeout     = w_done_to;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_grant && !w_sel_wen) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (w_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last <= w_win;
        if (!w_sel_wen) begin
          r_owner <= w_win;
          r_cnt   <= '0;
        end
      end else if (r_state == S_RD_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
